// File: rtl/data_memory_pkg.sv
// Shared definitions for the RV32 data memory: word sizes and address-to-index mapping.
package data_memory_pkg;

  localparam int XLEN       = 32;
  localparam int DMEM_WORDS = 1024;
  localparam int DMEM_IDX_W = 10;

  // Byte address to word index: drop the two byte-offset bits, then wrap to the array depth.
  // The depth must be a power of two so that the mask is a simple modulo.
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr,
                                                 input int unsigned     words);
    logic [XLEN-1:0] mask;
    mask = XLEN'(words - 1);
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory for the RV32 load/store path.
// One synchronous write port and one combinational read port with independent byte addresses.
// Contents come up with a fixed image and survive reset; reset only masks the read data
// and blocks writes while it is held.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_SIZE   = DMEM_WORDS,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [XLEN-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [XLEN-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  // The index mask only works as a modulo for power-of-two depths, and the word
  // width must match the core's register width.
  if ((MEM_SIZE < 4) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_bad_size
    $error("data_memory: MEM_SIZE must be a power of two and at least 4");
  end
  if (DATA_WIDTH != XLEN) begin : g_bad_width
    $error("data_memory: DATA_WIDTH must equal XLEN");
  end

  // Storage starts from the power-on image: word 1 = 1, word 2 = 0x10, everything else zero.
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE] = '{1: DATA_WIDTH'(32'h0000_0001),
                                            2: DATA_WIDTH'(32'h0000_0010),
                                            default: '0};

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic             wr_en;

  assign widx  = IDX_W'(word_index(waddr, MEM_SIZE));
  assign ridx  = IDX_W'(word_index(raddr, MEM_SIZE));

  // Only a clean logic 1 on we counts as a write request; X or Z leaves memory untouched.
  assign wr_en = (we == 1'b1);

  // Write port: commit on the clock edge; reset suppresses writes but never clears contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (wr_en) begin
      mem[widx] <= wdata;
    end
  end

  // Read port: zero-latency lookup with no wdata bypass, forced to zero while reset is held.
  always_comb begin
    rdata = '0;
    if (!rst) begin
      rdata = mem[ridx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector tables plus hand-written corner sequences,
// with expected read data queued at drive time and compared when the read is sampled.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [31:0] raddr;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] expected;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] expected;
  } exp_t;

  exp_t sb[$];

  vec_t rvec[7];
  vec_t wvec[7];

  data_memory dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs and record what rdata should read once it settles.
  task automatic applyStimulus(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] ra, input logic [31:0] exp, input string name);
    exp_t e;
    we    = w;
    waddr = wa;
    wdata = wd;
    raddr = ra;
    e.name     = name;
    e.expected = exp;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the current read data.
  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_underflow: no expectation queued, rdata=%08h", rdata);
    end else begin
      e = sb.pop_front();
      if (rdata !== e.expected) begin
        errors++;
        $display("[TB] FAIL %s: rdata=%08h expected=%08h", e.name, rdata, e.expected);
      end
    end
  endtask

  initial begin
    rvec[0] = '{1'b0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0001, "poweron_w1"};
    rvec[1] = '{1'b0, 32'h0, 32'h0, 32'h0000_0008, 32'h0000_0010, "poweron_w2"};
    rvec[2] = '{1'b0, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0000, "poweron_w0"};
    rvec[3] = '{1'b0, 32'h0, 32'h0, 32'h0000_000C, 32'h0000_0000, "poweron_w3"};
    rvec[4] = '{1'b0, 32'h0, 32'h0, 32'h0000_0007, 32'h0000_0001, "unaligned_read"};
    rvec[5] = '{1'b0, 32'h0, 32'h0, 32'h0000_1004, 32'h0000_0001, "wrap_read"};
    rvec[6] = '{1'b0, 32'h0, 32'h0, 32'h0000_0FFC, 32'h0000_0000, "top_word_read"};

    wvec[0] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, "basic_write"};
    wvec[1] = '{1'b0, 32'h0000_0000, 32'h5555_5555, 32'h0000_0008, 32'h0000_0010, "neighbour_kept"};
    wvec[2] = '{1'b1, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0000_0010, 32'hA5A5_A5A5, "unaligned_write"};
    wvec[3] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004, 32'h0000_0001, "write_disabled"};
    wvec[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1010, 32'hA5A5_A5A5, "wrap_after_write"};
    wvec[5] = '{1'b1, 32'h0000_2000, 32'h1111_2222, 32'h0000_0000, 32'h1111_2222, "wrap_write"};
    wvec[6] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_0FFC, 32'hCAFE_F00D, "top_word_write"};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, "reset_masks_rdata");
    #1;
    checkOutput();

    @(negedge clk);
    rst = 1'b0;

    // Power-on image and address mapping, all combinational within one cycle.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(rvec[i].we, rvec[i].waddr, rvec[i].wdata, rvec[i].raddr,
                    rvec[i].expected, rvec[i].name);
      #1;
      checkOutput();
    end

    // Single-edge writes, each read back just after the edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(wvec[i].we, wvec[i].waddr, wvec[i].wdata, wvec[i].raddr,
                    wvec[i].expected, wvec[i].name);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Read-during-write to the same word: old value before the edge, new value after.
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0000_000C, 32'h0000_0000, "rdw_before_edge");
    #1;
    checkOutput();
    sb.push_back('{"rdw_after_edge", 32'hDEAD_BEEF});
    @(posedge clk);
    #1;
    checkOutput();

    // Reset asserted mid-cycle masks rdata at once; a write during reset is dropped.
    @(negedge clk);
    we = 1'b0;
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_0008, 32'h0000_0000, "reset_mid_cycle");
    #1;
    checkOutput();
    applyStimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0008, 32'h0000_0000, "reset_write_held");
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_0008, 32'h0000_0010, "reset_write_dropped");
    #1;
    checkOutput();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_000C, 32'hDEAD_BEEF, "reset_keeps_writes");
    #1;
    checkOutput();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0001, "reset_keeps_image");
    #1;
    checkOutput();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
